frequency_counter_bcd: RTL and testbench

//  Parametrised successor frequency counter. Counts rising edges of an async input over a programmable gate of

---
 rtl/frequency_counter_bcd.sv | 267 ++++++++++++++++++++++++++
 tb/tb_frequency_counter_bcd.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_counter_bcd.sv
// -----------------------------------------------------------------------------
// frequency_counter_bcd
//
// Gated frequency counter with a BCD result and a scan-multiplexed 7-segment
// display. The asynchronous input is synchronised, and its rising edges are
// counted in DIGITS cascaded BCD counters for period_active clock cycles. At the
// end of the gate the result is copied to the display registers. Those registers
// are scanned one digit at a time onto a shared segment bus.
//
// Parameters
//   DIGITS          number of BCD display digits (1..8)
//   PERIOD_W        width of the gate period in clock cycles
//   DEFAULT_PERIOD  gate period loaded at reset
//   SCAN_W          scan prescaler width; the digit advances when it wraps
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   signal       asynchronous input to measure
//   period       new gate period (clocks)
//   period_load  level: the pending period takes 'period' on every cycle it is high
//   segments     active-high segments, bit0=a .. bit6=g, registered
//   digit_sel    one-hot active-high digit enable, bit0 = least-significant digit
//   valid        one-cycle pulse in the cycle the display registers take a result
//   overflow     high while the displayed result overflowed
//   dbg_state    FSM state: 00 IDLE, 01 COUNT, 10 LATCH
//
// Result strobe: 'valid' is a pure producer strobe with no ready/backpressure.
// It is high for exactly one cycle. In that same cycle the new display contents
// and 'overflow' are already visible. The segment bus follows one cycle later,
// because it is registered from the display registers.
// -----------------------------------------------------------------------------
module frequency_counter_bcd #(
  parameter int DIGITS         = 3,
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 1000,
  parameter int SCAN_W         = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                signal,
  input  logic [PERIOD_W-1:0] period,
  input  logic                period_load,
  output logic [6:0]          segments,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                valid,
  output logic                overflow,
  output logic [1:0]          dbg_state
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PERIOD_W-1:0] DEFAULT_P = PERIOD_W'(DEFAULT_PERIOD);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_LATCH = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Input path. Two synchroniser flops are followed by a history flop. The
  // rising-edge pulse is one cycle wide and is aligned to the synchronised level.
  // ---------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic hist;
  logic sig_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= signal;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign sig_rise = sync2 & ~hist;

  // ---------------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------------
  state_t                    state;
  logic [PERIOD_W-1:0]       gate_cnt;
  logic [PERIOD_W-1:0]       period_active;
  logic [PERIOD_W-1:0]       period_pending;
  logic [DIGITS-1:0][3:0]    bcd_q;
  logic [DIGITS-1:0][3:0]    bcd_inc;
  logic                      bcd_full;
  logic                      ovf_acc;
  logic [DIGITS-1:0][3:0]    display;

  assign dbg_state = state;

  // Ripple-carry BCD increment. A carry out of the top digit can only occur
  // when every digit is 9. That case is flagged as bcd_full, so the counters
  // saturate there instead of wrapping.
  always_comb begin
    logic carry;
    bcd_inc  = bcd_q;
    bcd_full = 1'b1;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i] != 4'd9) begin
        bcd_full = 1'b0;
      end
      if (carry) begin
        if (bcd_q[i] == 4'd9) begin
          bcd_inc[i] = 4'd0;
        end else begin
          bcd_inc[i] = bcd_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // Gate FSM. A measurement takes period_active COUNT cycles plus one LATCH
  // cycle. The period is double-buffered: period_load only touches
  // period_pending, which moves into period_active at LATCH. A running gate
  // is therefore never disturbed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      gate_cnt       <= '0;
      bcd_q          <= '0;
      ovf_acc        <= 1'b0;
      display        <= '0;
      overflow       <= 1'b0;
      valid          <= 1'b0;
      period_active  <= DEFAULT_P;
      period_pending <= DEFAULT_P;
    end else begin
      valid <= 1'b0;
      if (period_load) begin
        period_pending <= period;
      end

      case (state)
        ST_IDLE: begin
          if (period_active != '0) begin
            state    <= ST_COUNT;
            gate_cnt <= '0;
          end
        end

        ST_COUNT: begin
          gate_cnt <= gate_cnt + PERIOD_W'(1);
          if (sig_rise) begin
            if (bcd_full) begin
              ovf_acc <= 1'b1;
            end else begin
              bcd_q <= bcd_inc;
            end
          end
          if (gate_cnt == period_active - PERIOD_W'(1)) begin
            state <= ST_LATCH;
          end
        end

        ST_LATCH: begin
          // An edge seen in this cycle is deliberately not counted. The
          // counters are cleared here for the next gate.
          display       <= bcd_q;
          overflow      <= ovf_acc;
          valid         <= 1'b1;
          bcd_q         <= '0;
          ovf_acc       <= 1'b0;
          gate_cnt      <= '0;
          period_active <= period_pending;
          if (period_pending != '0) begin
            state <= ST_COUNT;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic [3:0]        cur_digit;
  logic              cur_shown;
  logic [6:0]        seg_next;

  function automatic logic [6:0] decode_bcd(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Leading-zero blanking. Walk from the top digit downward, remembering
  // whether a nonzero digit has been seen. The selected digit is shown if
  // it is at or below the most-significant nonzero digit. Digit 0 is always
  // shown, so a zero result still reads '0'.
  always_comb begin
    logic lead;
    cur_digit = 4'd0;
    cur_shown = 1'b0;
    lead      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (display[i] != 4'd0) begin
        lead = 1'b1;
      end
      if (digit_idx == IDX_W'(i)) begin
        cur_digit = display[i];
        cur_shown = lead || (i == 0);
      end
    end

    if (overflow) begin
      seg_next = 7'h40;
    end else if (cur_shown) begin
      seg_next = decode_bcd(cur_digit);
    end else begin
      seg_next = 7'h00;
    end
  end

  // digit_sel and segments are registered from the same digit_idx, so they
  // always change together and never show a digit with its neighbour's
  // pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      digit_sel <= '0;
      segments  <= 7'h00;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
      if (scan_cnt == '1) begin
        if (digit_idx == LAST_IDX) begin
          digit_idx <= '0;
        end else begin
          digit_idx <= digit_idx + IDX_W'(1);
        end
      end
      digit_sel <= DIGITS'(1) << digit_idx;
      segments  <= seg_next;
    end
  end

endmodule

// File: tb/tb_frequency_counter_bcd.sv
// -----------------------------------------------------------------------------
// tb_frequency_counter_bcd
//
// Directed bench for frequency_counter_bcd (DIGITS=3, PERIOD_W=16, SCAN_W=2).
//
// Each scoreboard entry describes one expected result:
//   [31:16]  clocks since the previous valid
//   [15:0]   expected count, or 16'hFFFF for overflow
// Entries are pushed when a gate's stimulus is set up. They are popped on
// valid. The following 16 cycles then check the scanned segment pattern of
// every digit.
// -----------------------------------------------------------------------------
module tb_frequency_counter_bcd;

  localparam int DIGITS = 3;
  localparam int PW     = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          sig_in;
  logic [PW-1:0] period;
  logic          period_load;
  logic [6:0]    segments;
  logic [2:0]    digit_sel;
  logic          valid;
  logic          overflow;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  frequency_counter_bcd #(
    .DIGITS        (DIGITS),
    .PERIOD_W      (PW),
    .DEFAULT_PERIOD(1000),
    .SCAN_W        (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .signal     (sig_in),
    .period     (period),
    .period_load(period_load),
    .segments   (segments),
    .digit_sel  (digit_sel),
    .valid      (valid),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          pulse_q[$];
  int          cyc        = 0;
  int          prev_valid = 0;
  int          n_cmp      = 0;
  int          n_err      = 0;
  int          n_valid    = 0;
  int          tog_half   = 0;
  int          tog_cnt    = 0;
  int          scan_left  = 0;
  int          cur_cnt    = 0;
  logic [2:0]  seen       = 3'b000;

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: timed out waiting for the DUT (cycle %0d)", tag, cyc);
  endtask

  function automatic logic [6:0] exp_seg(input int cnt, input int d);
    int p;
    int v;
    if (cnt < 0) return 7'h40;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    if (d > 0 && cnt < p) return 7'h00;
    v = (cnt / p) % 10;
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [31:0] entry(input int interval, input int cnt);
    return {16'(interval), 16'(cnt)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock step. Outputs are sampled and inputs are driven 1 time
  // unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;

    // Monitor
    if (valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_interval", 32'(cyc - prev_valid), 32'(e[31:16]));
        chk("overflow_flag", 32'(overflow), 32'(e[15:0] == 16'hFFFF));
        cur_cnt   = (e[15:0] == 16'hFFFF) ? -1 : int'(e[15:0]);
        scan_left = 16;
        seen      = 3'b000;
      end else begin
        scan_left = 0;
      end
      prev_valid = cyc;
    end else if (scan_left > 0) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (digit_sel === 3'(1 << i) && !seen[i]) begin
          seen[i] = 1'b1;
          chk($sformatf("seg_digit%0d", i), 32'(segments), 32'(exp_seg(cur_cnt, i)));
        end
      end
      scan_left--;
      if (scan_left == 0) chk("scan_all_digits", 32'(seen), 32'(3'b111));
    end

    // Input stimulus: either a square wave or scheduled one-cycle pulses
    if (tog_half > 0) begin
      tog_cnt++;
      if (tog_cnt >= tog_half) begin
        tog_cnt = 0;
        sig_in  = ~sig_in;
      end
    end else begin
      sig_in = 1'b0;
      while (pulse_q.size() > 0 && pulse_q[0] < cyc) void'(pulse_q.pop_front());
      if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
        sig_in = 1'b1;
        void'(pulse_q.pop_front());
      end
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (valid !== 1'b1 && n < budget);
    if (valid !== 1'b1) fail_now(tag);
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      fail_now(tag);
      exp_q.delete();
    end
  endtask

  task automatic start_scan(input int cnt);
    cur_cnt   = cnt;
    seen      = 3'b000;
    scan_left = 16;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int l;
    int g0;
    int r;
    int v0;

    reset       = 1'b1;
    sig_in      = 1'b0;
    period      = '0;
    period_load = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_state", 32'(dbg_state), 32'(2'b00));
    chk("rst_segments", 32'(segments), 32'(7'h00));
    chk("rst_digit_sel", 32'(digit_sel), 32'(3'b000));
    chk("rst_valid", 32'(valid), 32'(1'b0));
    chk("rst_overflow", 32'(overflow), 32'(1'b0));

    // Release; the default period is nonzero, so COUNT follows at once.
    // Load period 100 and start a 10-clock square wave.
    reset       = 1'b0;
    period      = 16'd100;
    period_load = 1'b1;
    start_scan(0);
    step();
    period_load = 1'b0;
    chk("idle_to_count", 32'(dbg_state), 32'(2'b01));
    tog_half = 5;
    wait_valid(1100, "default_gate_valid");

    // Three steady gates of 100: ten rises each, one result every 101 clocks
    exp_q.push_back(entry(101, 10));
    exp_q.push_back(entry(101, 10));
    exp_q.push_back(entry(101, 10));
    run_until_empty(400, "gate100");

    // Overflow: a 4000-clock gate with a rise every 2 clocks (2000 > 999).
    period      = 16'd4000;
    period_load = 1'b1;
    step();
    period_load = 1'b0;
    tog_half    = 1;
    tog_cnt     = 0;
    wait_valid(200, "gate_before_ovf");
    exp_q.push_back(entry(4001, 16'hFFFF));
    repeat (2500) step();
    period      = 16'd100;
    period_load = 1'b1;
    tog_half    = 5;
    tog_cnt     = 0;
    step();
    period_load = 1'b0;
    exp_q.push_back(entry(101, 10));
    run_until_empty(3000, "ovf_and_recover");

    // Period change mid-gate: load 50 at gate cycle 30 of a running 100 gate
    l = cyc;
    exp_q.push_back(entry(101, 10));
    exp_q.push_back(entry(51, 5));
    exp_q.push_back(entry(51, 5));
    while (cyc < l + 30) step();
    period      = 16'd50;
    period_load = 1'b1;
    step();
    period_load = 1'b0;
    run_until_empty(400, "period_change");

    // Gate boundaries with single pulses (period 50). A pin rise in cycle k
    // is counted in cycle k+2. Gate G0: rise at g=49 (last gate cycle). Gate
    // G1: rises at g=0, g=48, and g=50 (LATCH, dropped). Gate G2: rise at
    // g=10, which also shows that the dropped edge is not carried over.
    l        = cyc;
    tog_half = 0;
    g0       = l + 51;
    pulse_q  = '{g0 + 47, g0 + 49, g0 + 97, g0 + 99, g0 + 110};
    wait_valid(100, "boundary_start");
    chk("gate_len_50", 32'(cyc - l), 32'd51);
    exp_q.push_back(entry(51, 1));
    exp_q.push_back(entry(51, 2));
    exp_q.push_back(entry(51, 1));
    run_until_empty(300, "boundary_gates");

    // One-cycle reset in the middle of COUNT
    repeat (20) step();
    chk("mid_gate_state", 32'(dbg_state), 32'(2'b01));
    scan_left = 0;
    reset     = 1'b1;
    step();
    r = cyc;
    chk("mid_rst_state", 32'(dbg_state), 32'(2'b00));
    chk("mid_rst_segments", 32'(segments), 32'(7'h00));
    chk("mid_rst_digit_sel", 32'(digit_sel), 32'(3'b000));
    chk("mid_rst_overflow", 32'(overflow), 32'(1'b0));
    chk("mid_rst_valid", 32'(valid), 32'(1'b0));
    reset = 1'b0;
    start_scan(0);
    wait_valid(1100, "post_reset_valid");
    chk("post_reset_latency", 32'(cyc - r), 32'd1002);

    // Period 0: the current 1000 gate finishes with 3 rises, then IDLE
    l           = cyc;
    pulse_q     = '{l + 10, l + 20, l + 30};
    period      = 16'd0;
    period_load = 1'b1;
    step();
    period_load = 1'b0;
    exp_q.push_back(entry(1001, 3));
    run_until_empty(1100, "last_gate_before_idle");
    v0 = n_valid;
    repeat (300) step();
    chk("idle_no_valid", 32'(n_valid), 32'(v0));
    chk("idle_state", 32'(dbg_state), 32'(2'b00));
    start_scan(3);
    repeat (16) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
